alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width in bits.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port alu_op, input, 4 bits: operation select, type alu_op_t from riscv_32i_defs_pkg.
REQ-005 Port in_a, input, XLEN bits: operand A.
REQ-006 Port in_b, input, XLEN bits: operand B.
REQ-007 Port result, output, XLEN bits: registered operation result.
REQ-008 Port zero, output, 1 bit: registered flag, 1 when result equals 0.
REQ-009 The ports SHALL be bundled in interface alu_intf, which has modports for the DUT, assertions and coverage; all modports SHALL expose the same signal names as the ports.

Function
REQ-010 alu_op encodings SHALL be as follows:
- ALU_AND = 0000
- ALU_OR = 0001
- ALU_ADD = 0010
- ALU_XOR = 0011
- ALU_SLL = 0100
- ALU_SRL = 0101
- ALU_SUB = 0110
- ALU_SRA = 0111
- ALU_SLT = 1000
- ALU_SLTU = 1001
- 1010 through 1111 are invalid.
REQ-011 AND, OR and XOR SHALL be bitwise over all XLEN bits.
REQ-012 ADD SHALL compute in_a + in_b modulo 2^XLEN; carry-out SHALL be discarded, with no overflow flag.
REQ-013 SUB SHALL compute in_a - in_b modulo 2^XLEN; borrow SHALL be discarded, e.g. 0 - 1 = FFFFFFFF.
REQ-014 For SLL, SRL and SRA, the shift amount SHALL be in_b[4:0] and upper bits of in_b SHALL be ignored; SRA SHALL replicate in_a[XLEN-1].
REQ-015 SLT SHALL output 1 if in_a < in_b as signed two's complement, else 0; SLTU SHALL do the same comparison unsigned; bits [XLEN-1:1] of the output SHALL be 0.
REQ-016 Any invalid alu_op SHALL produce result = 0 and zero = 1; no X propagation and no latch SHALL occur.
REQ-017 The result of the operation on the inputs present at a rising edge of clk SHALL appear on result at that same edge; latency is 1 cycle, and outputs SHALL hold stable until the next edge.
REQ-018 zero SHALL be registered together with result at the same edge and SHALL equal (next result == 0).
REQ-019 Inputs SHALL be accepted every cycle, with no handshake, no stall and no backpressure; throughput is 1 operation per cycle.
REQ-020 The next-state logic SHALL be purely combinational from alu_op, in_a and in_b; no other internal state SHALL exist.

Reset
REQ-021 When rst_n = 0 at a rising edge, result SHALL become 0 and zero SHALL become 1, regardless of the inputs.
REQ-022 Reset SHALL take priority over any operation in the same cycle; the first operation after reset SHALL be the one whose inputs are present at the first edge with rst_n = 1.
REQ-023 Asserting reset in the middle of a stream of operations SHALL discard the in-flight result at that edge.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- ALU_AND with in_a = F0F0F0F0, in_b = 0FF00FF0 -> result = 00F000F0, zero = 0, one cycle later.
- ALU_ADD with FFFFFFFF + 00000001 -> result = 00000000, zero = 1 (wrap-around); ALU_ADD with 7FFFFFFF + 1 -> result = 80000000, zero = 0.
- ALU_SUB with 5 - 5 -> result = 0, zero = 1; ALU_SUB with 0 - 1 -> result = FFFFFFFF, zero = 0.
- ALU_SRA with in_a = 80000000, in_b = 00000024 (shift amount 4) -> result = F8000000; ALU_SLT with FFFFFFFF vs 1 -> result = 1; ALU_SLTU with FFFFFFFF vs 1 -> result = 0, zero = 1.
- alu_op = 1111 with random operands -> result = 0, zero = 1.
- rst_n = 0 during back-to-back ADDs -> at that edge result = 0 and zero = 1; after release, outputs resume with one-cycle latency.
REQ-025 Random regression SHALL check at least 1000 operations per valid op against a reference model, plus a fully unconstrained set.
REQ-026 Coverage SHALL include every op code, zero asserted and deasserted per op, operands of 0, all-ones and sign-bit-only, and carry or borrow cases.
REQ-027 Bound assertions SHALL check that zero == (result == 0) at every edge and that result is never X after reset.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: ALU operation encodings.
package riscv_32i_defs_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

endpackage

// File: rtl/alu_if.sv
// Port bundle for the ALU, with views for the design, assertions and coverage.
interface alu_intf
    import riscv_32i_defs_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic clk
);

    logic            rst_n;
    alu_op_t         alu_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] result;
    logic            zero;

    modport dut (
        input  clk, rst_n, alu_op, in_a, in_b,
        output result, zero
    );

    modport sva (
        input clk, rst_n, alu_op, in_a, in_b, result, zero
    );

    modport cov (
        input clk, rst_n, alu_op, in_a, in_b, result, zero
    );

endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU: result and zero flag update on every rising clock edge.
module alu
    import riscv_32i_defs_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  alu_op_t         alu_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [XLEN-1:0] result_d;
    logic [4:0]      shamt;

    assign shamt = in_b[4:0];

    always_comb begin
        result_d = '0;
        case (alu_op)
            ALU_AND:  result_d = in_a & in_b;
            ALU_OR:   result_d = in_a | in_b;
            ALU_ADD:  result_d = in_a + in_b;
            ALU_XOR:  result_d = in_a ^ in_b;
            ALU_SLL:  result_d = in_a << shamt;
            ALU_SRL:  result_d = in_a >> shamt;
            ALU_SUB:  result_d = in_a - in_b;
            ALU_SRA:  result_d = $signed(in_a) >>> shamt;
            ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, in_a < in_b};
            // Undefined encodings fall through to zero.
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= result_d;
            zero   <= (result_d == '0);
        end
    end

    zero_tracks_result: assert property (@(posedge clk) rst_n |-> (zero == (result == '0)));
    result_known:       assert property (@(posedge clk) rst_n |-> !$isunknown(result));

endmodule

// File: tb/tb_alu.sv
// Randomised scoreboard bench for alu against an arithmetic reference model.
module tb_alu;
    import riscv_32i_defs_pkg::*;

    localparam longint M = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    alu_op_t     alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [3:0]  op;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;
    int   zero_hit[16];
    int   nz_hit[16];

    always #5 clk = ~clk;

    alu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_op (alu_op),
        .in_a   (in_a),
        .in_b   (in_b),
        .result (result),
        .zero   (zero)
    );

    // Reference model computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ua, ub, sa, sb, p2, r;
        int     sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - M : ua;
        sb = b[31] ? ub - M : ub;
        sh = int'(b % 32);
        p2 = 64'd1 << sh;
        case (op)
            4'd0: r = longint'(a & b);
            4'd1: r = longint'(a | b);
            4'd2: r = (ua + ub) % M;
            4'd3: r = longint'(a ^ b);
            4'd4: r = (ua % (M / p2)) * p2;
            4'd5: r = ua / p2;
            4'd6: r = (ua - ub + M) % M;
            4'd7: r = (sa >= 0) ? sa / p2 : (sa - (p2 - 1)) / p2;
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rst, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        alu_op = alu_op_t'(op);
        in_a   = a;
        in_b   = b;
        e.res  = rst ? model(op, a, b) : 32'h0;
        e.z    = (e.res == 32'h0);
        e.op   = op;
        e.tag  = rst ? tag : {tag, "_rst"};
        exp_q.push_back(e);
    endtask

    // Directed check with a hand-computed expectation, cross-checking the model too.
    task automatic directed(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want, input string tag);
        checks++;
        if (model(op, a, b) !== want) begin
            errors++;
            $display("FAIL model_%s got=%08h want=%08h", tag, model(op, a, b), want);
        end
        issue(op, a, b, 1'b1, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (result !== e.res || zero !== e.z) begin
                    errors++;
                    $display("FAIL %s op=%0d result=%08h zero=%0b want result=%08h zero=%0b",
                             e.tag, e.op, result, zero, e.res, e.z);
                end
                if (e.z) zero_hit[e.op]++;
                else     nz_hit[e.op]++;
            end
        end
    end

    initial begin : stimulus
        int covered;
        rst_n  = 1'b0;
        alu_op = ALU_AND;
        in_a   = '0;
        in_b   = '0;
        issue(4'd2, 32'h1234_5678, 32'h1, 1'b0, "reset");
        issue(4'd2, 32'hDEAD_BEEF, 32'h1, 1'b0, "reset");

        directed(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, "and");
        directed(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
        directed(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_ovf");
        directed(4'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, "sub_eq");
        directed(4'd6, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_borrow");
        directed(4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra");
        directed(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt");
        directed(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu");
        directed(4'd4, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, "sll31");
        directed(4'd5, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, "srl0");
        for (int i = 0; i < 4; i++)
            directed(4'hF, 32'($urandom), 32'($urandom), 32'h0, "invalid");

        // Reset in the middle of back-to-back ADDs discards the in-flight result.
        issue(4'd2, 32'd10, 32'd20, 1'b1, "add_pre");
        issue(4'd2, 32'd30, 32'd40, 1'b1, "add_pre");
        issue(4'd2, 32'd50, 32'd60, 1'b0, "add_mid");
        issue(4'd2, 32'd70, 32'd80, 1'b1, "add_post");
        issue(4'd2, 32'hFFFF_FFFE, 32'd2, 1'b1, "add_post");

        for (int op = 0; op < 10; op++)
            for (int n = 0; n < 1000; n++)
                issue(4'(op), rand_operand(), rand_operand(), 1'b1, "rand");
        for (int n = 0; n < 1000; n++)
            issue(4'($urandom), 32'($urandom), 32'($urandom), 1'b1, "unconstrained");

        stim_done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        covered = 0;
        for (int op = 0; op < 10; op++)
            if (zero_hit[op] > 0 && nz_hit[op] > 0) covered++;
        $display("Coverage: %0d of 10 ops saw both zero and nonzero results", covered);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
